// File: rtl/ex_muldiv_if.sv
// ----------------------------------------------------------------------------
// ex_muldiv_if
// Bundle between the execute stage and the iterative RV32M mul/div unit.
//   master : pipeline side. Drives start/flush/op/src_a/src_b and
//            receives stall/busy/done/result.
//   slave  : ex_muldiv_unit side (the reverse directions).
// ----------------------------------------------------------------------------
interface ex_muldiv_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  start;   // M-op valid in EX
    logic                  flush;   // EX-stage flush, synchronous abort
    logic [2:0]            op;      // funct3
    logic [DATA_WIDTH-1:0] src_a;   // rs1 operand (post-forwarding)
    logic [DATA_WIDTH-1:0] src_b;   // rs2 operand (post-forwarding)
    logic                  stall;   // hold request to pipeline registers
    logic                  busy;    // unit not idle
    logic                  done;    // one-cycle result-valid pulse
    logic [DATA_WIDTH-1:0] result;  // held until the next done

    modport master (
        output start, flush, op, src_a, src_b,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, flush, op, src_a, src_b,
        output stall, busy, done, result
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative RV32M multiply/divide unit in the EX stage. One bit per cycle:
// shift-add multiply and restoring divide on operand magnitudes, with sign
// correction applied when the result is captured. Divide-by-zero and signed
// overflow complete on a one-cycle fast path.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   md_bus : ex_muldiv_if.slave (start/flush/op/src_a/src_b in,
//            stall/busy/done/result out)
// ----------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    ex_muldiv_if.slave   md_bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;      // apply two's-complement correction
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    hi_q, hi_d;        // mul: upper product / div: remainder
    logic [W-1:0]    lo_q, lo_d;        // mul: multiplier->lower product / div: dividend->quotient
    logic [W-1:0]    opnd_q, opnd_d;    // mul: multiplicand / div: divisor
    logic [W-1:0]    result_q, result_d;

    // Operand decode for the instruction being accepted.
    logic            is_div, signed_a, signed_b, a_neg, b_neg, start_neg;
    logic            div_by_zero, div_ovf;
    logic [W-1:0]    mag_a, mag_b;

    assign is_div      = md_bus.op[2];
    assign signed_a    = (md_bus.op == 3'b001) || (md_bus.op == 3'b010) ||
                         (md_bus.op == 3'b100) || (md_bus.op == 3'b110);
    assign signed_b    = (md_bus.op == 3'b001) || (md_bus.op == 3'b100) ||
                         (md_bus.op == 3'b110);
    assign a_neg       = signed_a && md_bus.src_a[W-1];
    assign b_neg       = signed_b && md_bus.src_b[W-1];
    assign mag_a       = a_neg ? -md_bus.src_a : md_bus.src_a;
    assign mag_b       = b_neg ? -md_bus.src_b : md_bus.src_b;
    // REM follows the dividend sign; everything else follows the sign product.
    assign start_neg   = (md_bus.op == 3'b110) ? a_neg : (a_neg ^ b_neg);
    assign div_by_zero = is_div && (md_bus.src_b == '0);
    assign div_ovf     = ((md_bus.op == 3'b100) || (md_bus.op == 3'b110)) &&
                         (md_bus.src_a == {1'b1, {(W-1){1'b0}}}) &&
                         (md_bus.src_b == '1);

    // One iteration of each datapath.
    logic [W:0]      mul_sum;
    logic [W:0]      div_shift;
    logic            div_ge;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {hi_q, lo_q[W-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};

    function automatic logic [W-1:0] final_result(input logic [2:0] op,
                                                  input logic       neg,
                                                  input logic [W-1:0] hi,
                                                  input logic [W-1:0] lo);
        logic [2*W-1:0] prod;
        logic [W-1:0]   res;
        prod = neg ? -{hi, lo} : {hi, lo};
        case (op)
            3'b000:                 res = prod[W-1:0];
            3'b001, 3'b010, 3'b011: res = prod[2*W-1:W];
            3'b100, 3'b101:         res = neg ? -lo : lo;
            default:                res = neg ? -hi : hi;
        endcase
        return res;
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (md_bus.start && !md_bus.flush) begin
                    op_d  = md_bus.op;
                    neg_d = start_neg;
                    if (div_by_zero) begin
                        result_d = md_bus.op[1] ? md_bus.src_a : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = md_bus.op[1] ? '0 : {1'b1, {(W-1){1'b0}}};
                        state_d  = S_DONE;
                    end else begin
                        hi_d    = '0;
                        lo_d    = is_div ? mag_a : mag_b;
                        opnd_d  = is_div ? mag_b : mag_a;
                        cnt_d   = CW'(W - 1);
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (md_bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q[2]) begin
                        hi_d = div_ge ? (div_shift[W-1:0] - opnd_q) : div_shift[W-1:0];
                        lo_d = {lo_q[W-2:0], div_ge};
                    end else begin
                        hi_d = mul_sum[W:1];
                        lo_d = {mul_sum[0], lo_q[W-1:1]};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d  = S_DONE;
                        result_d = final_result(op_q, neg_q, hi_d, lo_d);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

    // Stall is combinational on start so the instruction is held from the
    // very cycle it is accepted; it drops in DONE so the pipeline advances.
    assign md_bus.stall  = ((state_q == S_IDLE) && md_bus.start && !md_bus.flush) ||
                           (state_q == S_RUN);
    assign md_bus.busy   = (state_q != S_IDLE);
    assign md_bus.done   = (state_q == S_DONE);
    assign md_bus.result = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv_unit
// Self-checking bench for ex_muldiv_unit: directed cases, flush, back-to-back,
// mid-operation reset and randomized operations against a 64-bit arithmetic
// reference model.
// ----------------------------------------------------------------------------
module tb_ex_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_muldiv_if #(.DATA_WIDTH(32)) bus ();

    ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .md_bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_start  = 0;
    int t_done   = 0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: full-width arithmetic on sign/zero-extended operands.
    function automatic logic [31:0] ref_model(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ea, eb, p;
        longint      sa, sb;
        logic [31:0] r;
        if (!op[2]) begin
            ea = (op == 3'b001 || op == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
            eb = (op == 3'b001)                 ? {{32{b[31]}}, b} : {32'b0, b};
            p  = ea * eb;
            r  = (op == 3'b000) ? p[31:0] : p[63:32];
        end else begin
            if (op[0]) begin
                sa = longint'({32'b0, a});
                sb = longint'({32'b0, b});
            end else begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end
            if (b == 32'h0)  r = op[1] ? a : 32'hFFFF_FFFF;
            else if (op[1])  r = 32'(sa % sb);
            else             r = 32'(sa / sb);
        end
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && (b == 32'h0)) return 1;
        if ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return 33;
    endfunction

    task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        #1;
        t_start = cyc;
    endtask

    // Waits (bounded) for done; checks latency, stall window and result.
    // With scramble set, inputs are disturbed mid-run to prove no re-sampling.
    task automatic wait_done(input string tag, input int exp_lat,
                             input logic [31:0] exp_res, input bit scramble);
        int n = 0;
        int stalls = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            if (bus.stall === 1'b1) stalls++;
            @(negedge clk);
            #1;
            n++;
            if (scramble && n == 5) begin
                bus.src_a = $urandom;
                bus.src_b = $urandom;
                bus.op    = 3'($urandom_range(0, 7));
            end
        end
        check({tag, ":latency"}, 64'(n), 64'(exp_lat));
        check({tag, ":stall_cycles"}, 64'(stalls), 64'(exp_lat));
        check({tag, ":stall_at_done"}, 64'(bus.stall), 64'd0);
        check({tag, ":busy_at_done"}, 64'(bus.busy), 64'd1);
        check({tag, ":result"}, 64'(bus.result), 64'(exp_res));
        last_res  = exp_res;
        t_done    = cyc;
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        drive_op(op, a, b);
        wait_done(tag, exp_lat, exp_res, 1'b0);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_a;
        int done_count;
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;

        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = '0;
        bus.src_a = '0;
        bus.src_b = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset:stall",  64'(bus.stall),  64'd0);
        check("reset:busy",   64'(bus.busy),   64'd0);
        check("reset:done",   64'(bus.done),   64'd0);
        check("reset:result", 64'(bus.result), 64'd0);
        rst_n = 1'b1;

        // Directed operations.
        run_op("mulhu_ff",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE);
        run_op("mulh_min",    3'b001, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000);
        run_op("mul_neg",     3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 33, 32'hFFFF_FFEB);
        run_op("mulhsu",      3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 33, 32'hFFFF_FFFF);
        run_op("div_neg",     3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFD);
        run_op("rem_neg",     3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF);
        run_op("divu",        3'b101, 32'd100,       32'd7,         33, 32'd14);
        run_op("remu",        3'b111, 32'd100,       32'd7,         33, 32'd2);
        run_op("divu_by0",    3'b101, 32'd5,         32'd0,         1,  32'hFFFF_FFFF);
        run_op("rem_by0",     3'b110, 32'd5,         32'd0,         1,  32'd5);
        run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h8000_0000);
        run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h0);

        // Flush at T+10 of a DIVU; new MUL at T+11 completes at T+44.
        drive_op(3'b101, 32'd1000, 32'd3);
        t_a = t_start;
        done_count = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (bus.done === 1'b1) done_count++;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.op    = 3'b000;
        bus.src_a = 32'd3;
        bus.src_b = 32'd4;
        #1;
        check("flush:no_done",   64'(done_count), 64'd0);
        check("flush:idle",      64'(bus.busy),   64'd0);
        check("flush:done_low",  64'(bus.done),   64'd0);
        check("flush:result",    64'(bus.result), 64'(last_res));
        wait_done("flush_mul", 33, 32'd12, 1'b0);
        check("flush:abs_done",  64'(t_done - t_a), 64'd44);

        // Back-to-back: second start in the IDLE cycle after DONE.
        drive_op(3'b011, 32'h1234_5678, 32'h9ABC_DEF0);
        t_a = t_start;
        wait_done("b2b_first", 33, ref_model(3'b011, 32'h1234_5678, 32'h9ABC_DEF0), 1'b0);
        drive_op(3'b000, 32'h0000_0123, 32'h0000_0456);
        check("b2b:second_start", 64'(t_start - t_a), 64'd34);
        wait_done("b2b_second", 33, 32'h0004_EDC2, 1'b0);
        check("b2b:abs_done", 64'(t_done - t_a), 64'd67);

        // Reset in the middle of a MUL; the pipeline drops start alongside it.
        drive_op(3'b000, 32'd9, 32'd9);
        repeat (5) @(negedge clk);
        rst_n     = 1'b0;
        bus.start = 1'b0;
        #1;
        check("rst_mid:stall",  64'(bus.stall),  64'd0);
        check("rst_mid:busy",   64'(bus.busy),   64'd0);
        check("rst_mid:done",   64'(bus.done),   64'd0);
        check("rst_mid:result", 64'(bus.result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_count = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (bus.done === 1'b1) done_count++;
        end
        check("rst_mid:no_done", 64'(done_count), 64'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 50; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = rand_opnd();
            r_b  = rand_opnd();
            if ($urandom_range(0, 9) == 0 && r_op[2]) begin
                r_a = 32'h8000_0000;
                r_b = 32'hFFFF_FFFF;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            drive_op(r_op, r_a, r_b);
            wait_done($sformatf("rand%0d_op%0d", i, r_op), ref_latency(r_op, r_a, r_b),
                      ref_model(r_op, r_a, r_b), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Execute-stage consumer of the ID/EX operand/control bundle for RV32M instructions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Reads RD1E/RD2E-derived operands and funct3 when the M-op valid is high.
- Computes the result iteratively (one bit per cycle).
- Drives a stall request back to the PC/IF-ID/ID-EX registers until the result is ready, so the pipeline holds the instruction in EX for the full operation.

Parameters:
DATA_WIDTH, 32, operand/result width (only 32 supported; iteration count = DATA_WIDTH)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  M-extension op valid in EX (held stable by the stall)
flush  input  1  EX-stage flush (branch/jump taken); synchronous abort
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a  input  DATA_WIDTH  rs1 operand (post-forwarding)
src_b  input  DATA_WIDTH  rs2 operand (post-forwarding)
stall  output  1  hold request to pipeline registers
busy  output  1  state != IDLE
done  output  1  one-cycle result-valid pulse
result  output  DATA_WIDTH  final result, held until next done

Behaviour:
- States: IDLE, RUN, DONE. Reset: state IDLE, result 0, done 0, internal counter/accumulators 0.
- stall = (state==IDLE && start && !flush) || state==RUN. stall is 0 in DONE, so the pipeline advances on the DONE cycle and captures result.
- IDLE + start (no flush):
  - Latch op, sign flags and operand magnitudes.
  - Signed operand: src_a signed for MULH/MULHSU/DIV/REM; src_b signed for MULH/DIV/REM.
  - Fast path (divide ops only), go directly to DONE:
    - src_b==0: quotient = all ones; remainder = src_a.
    - DIV/REM with src_a==0x80000000 && src_b==0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - Otherwise go to RUN with counter = DATA_WIDTH-1.
- RUN: one iteration per cycle; counter decrements; after the counter==0 iteration, go to DONE. RUN lasts exactly DATA_WIDTH cycles.
  - Multiply: unsigned shift-add of magnitudes into a 2*DATA_WIDTH product; negate if operand signs differ.
    - MUL returns the low half.
    - MULH/MULHSU/MULHU return the high half.
  - Divide: restoring division on magnitudes.
    - Quotient negated if signs differ (DIV).
    - Remainder takes the dividend sign (REM).
- DONE: result register updated on entry; done=1 for exactly this cycle; start is ignored; next state IDLE.
- Latency: start sampled in cycle T.
  - Normal ops: RUN T+1..T+32, done at T+33; stall high T..T+32.
  - Fast path: done at T+1; stall high at T only.
- A new start in the IDLE cycle after DONE begins a new op (back-to-back M-ops allowed).
- flush:
  - Highest synchronous priority: next state IDLE, no done pulse, result unchanged.
  - flush in DONE: done still pulses this cycle; next state IDLE.
- start while RUN: ignored; op/operands are not re-sampled.
- Reset asserted mid-operation: immediate return to reset values; no done afterwards.
- Sign correction uses two's-complement negate at full width; no X propagation on any output after reset.

Test Plan:
- MULHU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> done at T+33, result 0xFFFFFFFE; stall high T..T+32, low at T+33.
- MULH 0x80000000×0x80000000 -> 0x40000000. MUL 0xFFFFFFFD×0x00000007 -> 0xFFFFFFEB. MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each done at T+1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, done at T+1.
- DIVU started at T, flush at T+10 -> state IDLE at T+11, no done, result retains prior value; new MUL 3×4 started at T+11 -> 12 at T+44.
- rst_n low at T+5 of a MUL -> stall/busy/done/result all 0 immediately. Back-to-back ops: second start at T+34 (IDLE after DONE) -> done at T+67.
